// File: rtl/spi_regfile_subnode_pkg.sv
// Shared definitions for the SPI register-file subnode: command layout,
// FSM states and address-map classification.
package spi_regfile_subnode_pkg;

    localparam int unsigned CMD_W      = 5;
    localparam int unsigned CMD_RD_BIT = 4;
    localparam int unsigned ADDR_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        AK_DATA,
        AK_MODE,
        AK_STATUS,
        AK_NONE
    } addr_kind_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Classify an address: data regs, then mode, then status words, then nothing
    function automatic addr_kind_e addr_kind(input logic [ADDR_W-1:0] a,
                                             input int unsigned       num_regs,
                                             input int unsigned       num_status);
        int unsigned ai;
        ai = 32'(a);
        if (ai < num_regs)               return AK_DATA;
        if (ai == num_regs)              return AK_MODE;
        if (ai <= num_regs + num_status) return AK_STATUS;
        return AK_NONE;
    endfunction

endpackage

// File: rtl/spi_regfile_subnode_if.sv
// SPI pin bundle between the host (master) and the register-file subnode (slave).
interface spi_regfile_subnode_if;
    logic sck;
    logic csb;
    logic mosi;
    logic miso;

    modport master (output sck, output csb, output mosi, input miso);
    modport slave  (input sck, input csb, input mosi, output miso);
endinterface

// File: rtl/spi_regfile_subnode_pin_sync.sv
// Two-flop synchronisers for the asynchronous SPI pins plus edge pulses
// derived from the synchronised sck and csb.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_pin,
    input  logic csb_pin,
    input  logic mosi_pin,
    output logic sck_rise,
    output logic sck_fall,
    output logic csb_sync,
    output logic csb_fall,
    output logic mosi_sync
);
    // [0],[1] are the synchroniser; [2] holds the previous synced value for edges
    logic [2:0] sck_q;
    logic [2:0] csb_q;
    logic [1:0] mosi_q;

    // Pin synchronisers; csb resets deselected so reset release is not a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            csb_q  <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck_pin};
            csb_q  <= {csb_q[1:0], csb_pin};
            mosi_q <= {mosi_q[0], mosi_pin};
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign csb_sync  = csb_q[1];
    assign csb_fall  = ~csb_q[1] & csb_q[2];
    assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/spi_regfile_subnode.sv
// System-clocked SPI mode-0 subnode: writable data registers, a mode register
// and read-only status words, with burst auto-increment and atomic commits.
module spi_regfile_subnode
    import spi_regfile_subnode_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 3,
    parameter int unsigned REG_WIDTH    = 128,
    parameter int unsigned NUM_STATUS   = 5,
    parameter int unsigned STATUS_WIDTH = 64,
    parameter int unsigned MODE_WIDTH   = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    spi_regfile_subnode_if.slave               spi,
    output logic [NUM_REGS*REG_WIDTH-1:0]      regs_flat,
    output logic [NUM_REGS-1:0]                reg_wr_pulse,
    output logic [MODE_WIDTH-1:0]              operation_mode,
    output logic                               op_start,
    output logic                               cmd_err,
    input  logic [NUM_STATUS*STATUS_WIDTH-1:0] status_flat
);
    localparam int unsigned WR_W  = max2(REG_WIDTH, MODE_WIDTH);
    localparam int unsigned SH_W  = WR_W - 1;
    localparam int unsigned RD_W  = max2(WR_W, STATUS_WIDTH);
    localparam int unsigned CNT_W = $clog2(max2(RD_W, CMD_W));

    localparam logic [CNT_W-1:0]  CMD_LAST     = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST    = CNT_W'(REG_WIDTH - 1);
    localparam logic [CNT_W-1:0]  MODE_LAST    = CNT_W'(MODE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  STAT_LAST    = CNT_W'(STATUS_WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_DATA    = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_STATUS = ADDR_W'(NUM_REGS + 1);
    localparam logic [ADDR_W-1:0] LAST_STATUS  = ADDR_W'(NUM_REGS + NUM_STATUS);

    logic sck_rise, sck_fall, csb_sync, csb_fall, mosi_sync;

    state_e                 state;
    logic [CMD_W-2:0]       cmd_sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_W-1:0]      addr;
    logic [SH_W-1:0]        shadow;
    logic [RD_W-1:0]        rd_sr;
    logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];
    logic                   mode_seen;
    logic                   miso_q;

    logic [CMD_W-1:0]       cmd_word;
    logic                   dec_rd, dec_legal, mode_commit;
    logic [ADDR_W-1:0]      dec_addr, next_addr, sel_addr;
    addr_kind_e             dec_kind, cur_kind, sel_kind;
    logic [CNT_W-1:0]       sel_last;
    logic [RD_W-1:0]        sel_snap;
    logic [WR_W-1:0]        wr_word;

    spi_pin_sync u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_pin   (spi.sck),
        .csb_pin   (spi.csb),
        .mosi_pin  (spi.mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .csb_sync  (csb_sync),
        .csb_fall  (csb_fall),
        .mosi_sync (mosi_sync)
    );

    assign spi.miso = miso_q;

    // Command decode, auto-increment target and the word snapshot for the next target
    always_comb begin
        cmd_word  = {cmd_sr, mosi_sync};
        dec_rd    = cmd_word[CMD_RD_BIT];
        dec_addr  = cmd_word[ADDR_W-1:0];
        dec_kind  = addr_kind(dec_addr, NUM_REGS, NUM_STATUS);
        dec_legal = (dec_kind != AK_NONE) && (dec_rd || (dec_kind != AK_STATUS));
        cur_kind  = addr_kind(addr, NUM_REGS, NUM_STATUS);
        wr_word   = {shadow, mosi_sync};

        case (cur_kind)
            AK_DATA:   next_addr = (addr == LAST_DATA) ? '0 : addr + ADDR_W'(1);
            AK_STATUS: next_addr = (addr == LAST_STATUS) ? FIRST_STATUS : addr + ADDR_W'(1);
            default:   next_addr = addr;
        endcase

        // In CMD the decoded address is loaded; otherwise the word boundary target
        sel_addr = (state == ST_CMD) ? dec_addr : next_addr;
        sel_kind = addr_kind(sel_addr, NUM_REGS, NUM_STATUS);
        sel_last = '0;
        sel_snap = '0;
        case (sel_kind)
            AK_DATA: begin
                sel_last = DATA_LAST;
                for (int unsigned i = 0; i < NUM_REGS; i++)
                    if (sel_addr == ADDR_W'(i)) sel_snap[RD_W-1 -: REG_WIDTH] = regs_q[i];
            end
            AK_MODE: begin
                sel_last = MODE_LAST;
                sel_snap[RD_W-1 -: MODE_WIDTH] = operation_mode;
            end
            AK_STATUS: begin
                sel_last = STAT_LAST;
                for (int unsigned i = 0; i < NUM_STATUS; i++)
                    if (sel_addr == ADDR_W'(NUM_REGS + 1 + i))
                        sel_snap[RD_W-1 -: STATUS_WIDTH] = status_flat[i*STATUS_WIDTH +: STATUS_WIDTH];
            end
            default: ;
        endcase

        mode_commit = (state == ST_WR_DATA) && sck_rise && (bit_cnt == '0) && (cur_kind == AK_MODE);
    end

    // Flatten the register array onto the output bus
    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            regs_flat[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
    end

    // Transaction FSM: command shift, word shift/commit, readout and csb abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cmd_sr         <= '0;
            bit_cnt        <= '0;
            addr           <= '0;
            shadow         <= '0;
            rd_sr          <= '0;
            regs_q         <= '{default: '0};
            operation_mode <= '0;
            reg_wr_pulse   <= '0;
            op_start       <= 1'b0;
            cmd_err        <= 1'b0;
            mode_seen      <= 1'b0;
            miso_q         <= 1'b1;
        end else begin
            reg_wr_pulse <= '0;
            op_start     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso_q <= 1'b1;
                    if (csb_fall) begin
                        state     <= ST_CMD;
                        cmd_sr    <= '0;
                        bit_cnt   <= CMD_LAST;
                        mode_seen <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_sr  <= cmd_word[CMD_W-2:0];
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            addr <= dec_addr;
                            if (!dec_legal) begin
                                state   <= ST_IGNORE;
                                cmd_err <= 1'b1;
                            end else if (dec_rd) begin
                                state   <= ST_RD_DATA;
                                cmd_err <= 1'b0;
                                rd_sr   <= sel_snap;
                                bit_cnt <= sel_last;
                            end else begin
                                state   <= ST_WR_DATA;
                                cmd_err <= 1'b0;
                                shadow  <= '0;
                                bit_cnt <= sel_last;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sck_rise) begin
                        shadow  <= wr_word[SH_W-1:0];
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            if (cur_kind == AK_MODE) begin
                                operation_mode <= wr_word[MODE_WIDTH-1:0];
                                mode_seen      <= 1'b1;
                            end else begin
                                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                    if (addr == ADDR_W'(i)) begin
                                        regs_q[i]       <= wr_word[REG_WIDTH-1:0];
                                        reg_wr_pulse[i] <= 1'b1;
                                    end
                                end
                            end
                            addr    <= next_addr;
                            bit_cnt <= sel_last;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (sck_fall) begin
                        miso_q <= rd_sr[RD_W-1];
                        rd_sr  <= {rd_sr[RD_W-2:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            addr    <= next_addr;
                            rd_sr   <= sel_snap;
                            bit_cnt <= sel_last;
                        end
                    end
                end
                ST_IGNORE: miso_q <= 1'b1;
                default:   state  <= ST_IDLE;
            endcase

            // Deselect overrides the state update above, after any same-clk commit
            if (csb_sync) begin
                state     <= ST_IDLE;
                miso_q    <= 1'b1;
                mode_seen <= 1'b0;
                if (state != ST_IDLE) op_start <= mode_seen | mode_commit;
            end
        end
    end

endmodule
